// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Sequences one frame at a time: grant, start pulse, wait for busy to rise, then fall.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned IDXW        = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic [IDXW-1:0]      owner,
  output logic                 err,
  output logic [15:0]          sent_count
);

  localparam int unsigned CNTW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CNTW-1:0]  cnt_inc_c;
  logic [15:0]      sent_count_q, sent_count_d;

  logic             found_c;
  logic [IDXW-1:0]  grant_c;
  logic [IDXW-1:0]  idx_c;

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    found_c = 1'b0;
    grant_c = last_q;
    idx_c   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx_c = IDXW'((32'(last_q) + off) % N_REQ);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        grant_c = idx_c;
      end
    end
  end

  assign cnt_inc_c = cnt_q + CNTW'(1);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    tx_data_d    = tx_data_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    sent_count_d = sent_count_q;

    unique case (state_q)
      IDLE: begin
        // A transmitter still busy from before a reset must finish before any grant.
        if (!tx_busy && found_c) begin
          state_d        = START;
          tx_data_d      = req_data[8*grant_c +: 8];
          owner_d        = grant_c;
          last_d         = grant_c;
          ack_d[grant_c] = 1'b1;
          tx_start_d     = 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc_c == CNTW'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d      = IDLE;
          sent_count_d = sent_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IDXW'(N_REQ - 1);
      owner_q      <= '0;
      tx_data_q    <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      tx_data_q    <= tx_data_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign ack        = ack_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign err        = err_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued when requests are raised
// and popped by a monitor whenever the arbiter issues a start pulse.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned IDXW        = 2;
  localparam int unsigned ACK_TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     ack;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 busy;
  logic [IDXW-1:0]      owner;
  logic                 err;
  logic [15:0]          sent_count;

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .IDXW(IDXW), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy),
    .owner(owner), .err(err), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy rises tx_dly cycles after start and stays high tx_len cycles.
  int tx_dly   = 3;
  int tx_len   = 10;
  bit tx_never = 1'b0;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !tx_never) begin
        repeat (tx_dly) @(negedge clk);
        tx_busy = 1'b1;
        repeat (tx_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: each grant must match the oldest queued {index, byte}.
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  int grants_seen = 0;
  int start_cyc   = 0;
  always @(negedge clk) begin
    if (!rst && (tx_start || ack != '0)) begin
      if (exp_q.size() == 0) begin
        check("spurious_grant", 32'(ack), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("grant_ack",   32'(ack),      32'(1) << mon_e[9:8]);
        check("grant_start", 32'(tx_start), 32'(1));
        check("grant_data",  32'(tx_data),  32'(mon_e[7:0]));
        check("grant_owner", 32'(owner),    32'(mon_e[9:8]));
      end
      grants_seen++;
      start_cyc = cyc;
    end
  end

  task automatic wait_grants(input int n, input string tag);
    int b = 0;
    while (grants_seen < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (grants_seen < n) check(tag, 32'(grants_seen), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while ((busy || tx_busy) && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (busy || tx_busy) check(tag, 32'(busy), 32'(0));
  endtask

  task automatic chk_zero(input string pfx);
    check({pfx, "_ack"},        32'(ack),        32'(0));
    check({pfx, "_tx_start"},   32'(tx_start),   32'(0));
    check({pfx, "_tx_data"},    32'(tx_data),    32'(0));
    check({pfx, "_busy"},       32'(busy),       32'(0));
    check({pfx, "_owner"},      32'(owner),      32'(0));
    check({pfx, "_err"},        32'(err),        32'(0));
    check({pfx, "_sent_count"}, 32'(sent_count), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b;
    bit early;
    req      = '0;
    req_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single requester, grant one cycle after the request is sampled.
    req_data[7:0] = 8'h55;
    exp_q.push_back({2'd0, 8'h55});
    req = 4'b0001;
    @(negedge clk);
    check("t1_tx_start", 32'(tx_start), 32'(1));
    check("t1_ack",      32'(ack),      32'(4'b0001));
    check("t1_tx_data",  32'(tx_data),  32'(8'h55));
    check("t1_busy",     32'(busy),     32'(1));
    req = '0;
    wait_idle("t1_idle_timeout");
    check("t1_sent_count", 32'(sent_count), 32'(1));
    check("t1_busy_after", 32'(busy),       32'(0));

    // All four requesting: round-robin from index 0 after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_dly = 1;
    tx_len = 4;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    base = grants_seen;
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 8'(32'hA0 + i % 4)});
    req = 4'hF;
    wait_grants(base + 8, "t2_grant_timeout");
    req = '0;
    wait_idle("t2_idle_timeout");
    check("t2_sent_count", 32'(sent_count), 32'(8));
    check("t2_owner",      32'(owner),      32'(3));

    // Transmitter never responds: err exactly ACK_TIMEOUT cycles after START.
    tx_never = 1'b1;
    req_data[23:16] = 8'h3C;
    exp_q.push_back({2'd2, 8'h3C});
    base = grants_seen;
    req = 4'b0100;
    wait_grants(base + 1, "t3_grant_timeout");
    req = '0;
    b = 0;
    while (!err && b < 60) begin
      @(negedge clk);
      b++;
    end
    check("t3_err_seen",  32'(err),             32'(1));
    check("t3_err_delay", 32'(cyc - start_cyc), 32'(ACK_TIMEOUT));
    @(negedge clk);
    check("t3_err_pulse", 32'(err),        32'(0));
    check("t3_busy",      32'(busy),       32'(0));
    check("t3_sent_hold", 32'(sent_count), 32'(8));
    tx_never = 1'b0;
    tx_dly = 2;
    tx_len = 3;
    req_data[31:24] = 8'h77;
    exp_q.push_back({2'd3, 8'h77});
    req = 4'b1000;
    wait_grants(base + 2, "t3_next_timeout");
    req = '0;
    wait_idle("t3_idle_timeout");
    check("t3_sent_after", 32'(sent_count), 32'(9));

    // Reset during WAIT_DONE with the transmitter still busy.
    tx_dly = 1;
    tx_len = 30;
    req_data[15:8] = 8'h12;
    exp_q.push_back({2'd1, 8'h12});
    base = grants_seen;
    req = 4'b0010;
    wait_grants(base + 1, "t4_grant_timeout");
    req_data[15:8] = 8'h34;
    b = 0;
    while (!tx_busy && b < 20) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check("t4_pre_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    chk_zero("t4_rst");
    exp_q.push_back({2'd1, 8'h34});
    @(negedge clk);
    rst = 1'b0;
    early = 1'b0;
    b = 0;
    while (tx_busy && b < 60) begin
      @(negedge clk);
      if (ack != '0 || tx_start) early = 1'b1;
      b++;
    end
    check("t4_no_grant_while_txbusy", 32'(early),   32'(0));
    check("t4_txbusy_fell",           32'(tx_busy), 32'(0));
    wait_grants(base + 2, "t4_regrant_timeout");
    req = '0;
    wait_idle("t4_idle_timeout");
    check("t4_owner", 32'(owner),      32'(1));
    check("t4_sent",  32'(sent_count), 32'(1));

    // Counter wrap: preload to 0xFFFF, one more frame wraps to 0.
    tx_dly = 1;
    tx_len = 2;
    @(negedge clk);
    force dut.sent_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_count_q;
    @(negedge clk);
    check("t5_preload", 32'(sent_count), 32'(16'hFFFF));
    req_data[23:16] = 8'hC3;
    exp_q.push_back({2'd2, 8'hC3});
    base = grants_seen;
    req = 4'b0100;
    wait_grants(base + 1, "t5_grant_timeout");
    req = '0;
    wait_idle("t5_idle_timeout");
    check("t5_wrap",        32'(sent_count),   32'(0));
    check("t5_owner",       32'(owner),        32'(2));
    check("queue_drained",  32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
